// File: rtl/shared_bus_arbiter.sv
// Three-master shared bus arbiter (CPU=0, CCD=1, ACC=2): registered round-robin grant
// with a burst limit and one-cycle read return. Define SHARED_BUS_CPU_PRIO_EN for CPU priority.
module shared_bus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req_i,
    input  logic [2:0]            we_i,
    input  logic [3*ADDR_W-1:0]   addr_i,
    input  logic [3*DATA_W-1:0]   wdata_i,
    output logic [2:0]            gnt_o,
    output logic [2:0]            rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  stall_o,
    output logic                  bus_en_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic [DATA_W-1:0]     bus_rdata_i
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state_q;
    logic [2:0]       gnt_q;
    logic [1:0]       last_q;
    logic [CNT_W-1:0] burst_q;
    logic [2:0]       rvalid_q;

    logic [2:0] others;
    logic [2:0] pick_all;
    logic [2:0] pick_oth;
    logic       owner_req;
    logic       preempt;
    logic       rotate_ok;

    // Round-robin search starting just after the last owner.
    function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
        logic [2:0] res;
        res = 3'b000;
`ifdef SHARED_BUS_CPU_PRIO_EN
        if (mask[0]) begin
            res = 3'b001;
        end
`endif
        for (int i = 1; i <= 3; i++) begin
            int k;
            k = (int'(last) + i) % 3;
            if (res == 3'b000 && mask[k]) begin
                res[k] = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [1:0] oh2idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

    assign others    = req_i & ~gnt_q;
    assign pick_all  = rr_pick(req_i, last_q);
    assign pick_oth  = rr_pick(others, last_q);
    assign owner_req = |(req_i & gnt_q);

`ifdef SHARED_BUS_CPU_PRIO_EN
    assign preempt   = req_i[0] & ~gnt_q[0];
    assign rotate_ok = ~gnt_q[0];
`else
    assign preempt   = 1'b0;
    assign rotate_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 3'b000;
            last_q   <= 2'd2;
            burst_q  <= '0;
            rvalid_q <= 3'b000;
        end else begin
            rvalid_q <= gnt_q & req_i & ~we_i;
            case (state_q)
                IDLE: begin
                    burst_q <= '0;
                    if (|req_i) begin
                        state_q <= OWN;
                        gnt_q   <= pick_all;
                        last_q  <= oh2idx(pick_all);
                    end
                end
                OWN: begin
                    if (!owner_req) begin
                        burst_q <= '0;
                        if (|others) begin
                            gnt_q  <= pick_oth;
                            last_q <= oh2idx(pick_oth);
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= 3'b000;
                        end
                    end else if (preempt) begin
                        gnt_q   <= 3'b001;
                        last_q  <= 2'd0;
                        burst_q <= '0;
                    end else if (burst_q == BURST_LAST) begin
                        // At the limit: hand over if anyone waits, else hold and saturate.
                        if ((|others) && rotate_ok) begin
                            gnt_q   <= pick_oth;
                            last_q  <= oh2idx(pick_oth);
                            burst_q <= '0;
                        end
                    end else begin
                        burst_q <= burst_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 3'b000;
                    burst_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        for (int k = 0; k < 3; k++) begin
            if (gnt_q[k]) begin
                bus_we_o    = we_i[k];
                bus_addr_o  = addr_i[k*ADDR_W +: ADDR_W];
                bus_wdata_o = wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign bus_en_o = owner_req;
    assign gnt_o    = gnt_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = (|rvalid_q) ? bus_rdata_i : '0;
    assign stall_o  = req_i[0] & ~gnt_q[0];

endmodule
